// File: rtl/wind_mode_conditioner.sv
// rtl/wind_mode_conditioner.sv - wind switch synchroniser, debouncer and step pulse generator
// Optional: define WIND_FAULT_EN to reject code 11 and raise fault instead of accepting it.
module wind_mode_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP_PERIOD     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] sw_in,
  output logic [1:0] mode,
  output logic       mode_changed,
  output logic       step,
  output logic       fault
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int SW = $clog2(STEP_PERIOD) + 1;
  // count value that, observed once more, completes the debounce window
  localparam logic [DW-1:0] DB_PRE  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SP_LAST = SW'(STEP_PERIOD - 1);

  typedef enum logic {STABLE, PENDING} state_t;

  state_t          state;
  logic [1:0]      s1, s2;
  logic [1:0]      candidate;
  logic [DW-1:0]   db_cnt;
  logic [SW-1:0]   step_cnt;
  logic            obs_hit;
  logic            accept;
  logic            step_hold;

  // Decide whether this edge completes a debounce window, and whether it is accepted
  always_comb begin
    obs_hit = 1'b0;
    if (state == STABLE) begin
      obs_hit = (s2 != mode) && (DEBOUNCE_CYCLES == 1);
    end else begin
      obs_hit = (s2 != mode) && (s2 == candidate) && (db_cnt == DB_PRE);
    end
  end

`ifdef WIND_FAULT_EN
  logic illegal_hit;
  assign illegal_hit = obs_hit && (s2 == 2'b11);
  assign accept      = obs_hit && (s2 != 2'b11);
  // an illegal acceptance attempt restarts the period just like a real acceptance
  assign step_hold   = obs_hit || fault;

  // Fault flag: set when 11 survives the debounce window, cleared once s2 leaves 11
  always_ff @(posedge clk) begin
    if (reset) begin
      fault <= 1'b0;
    end else if (illegal_hit) begin
      fault <= 1'b1;
    end else if (s2 != 2'b11) begin
      fault <= 1'b0;
    end
  end
`else
  assign accept    = obs_hit;
  assign step_hold = obs_hit;
  assign fault     = 1'b0;
`endif

  // Synchroniser plus debounce FSM; mode and mode_changed are registered here
  always_ff @(posedge clk) begin
    if (reset) begin
      s1           <= 2'b00;
      s2           <= 2'b00;
      state        <= STABLE;
      candidate    <= 2'b00;
      db_cnt       <= '0;
      mode         <= 2'b00;
      mode_changed <= 1'b0;
    end else begin
      s1           <= sw_in;
      s2           <= s1;
      mode_changed <= accept;
      if (accept) begin
        mode <= s2;
      end
      case (state)
        STABLE: begin
          if (s2 != mode) begin
            candidate <= s2;
            if (!obs_hit) begin
              state  <= PENDING;
              db_cnt <= DW'(1);
            end else begin
              db_cnt <= '0;
            end
          end else begin
            db_cnt <= '0;
          end
        end
        PENDING: begin
          if ((s2 == mode) || obs_hit) begin
            state  <= STABLE;
            db_cnt <= '0;
          end else if (s2 == candidate) begin
            db_cnt <= db_cnt + DW'(1);
          end else begin
            candidate <= s2;
            db_cnt    <= DW'(1);
          end
        end
        default: begin
          state  <= STABLE;
          db_cnt <= '0;
        end
      endcase
    end
  end

  // Step generator: one-cycle pulse after each wrap, restarted by acceptance or fault
  always_ff @(posedge clk) begin
    if (reset) begin
      step_cnt <= '0;
      step     <= 1'b0;
    end else if (step_hold) begin
      step_cnt <= '0;
      step     <= 1'b0;
    end else if (step_cnt == SP_LAST) begin
      step_cnt <= '0;
      step     <= 1'b1;
    end else begin
      step_cnt <= step_cnt + SW'(1);
      step     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wind_mode_conditioner.sv
// tb/tb_wind_mode_conditioner.sv - scoreboard bench for wind_mode_conditioner
module tb_wind_mode_conditioner;

  localparam int END_CYC = 128;

  logic       clk;
  logic       reset;
  logic [1:0] sw_in;
  logic [1:0] mode;
  logic       mode_changed;
  logic       step;
  logic       fault;

  int n_cmp;
  int n_bad;
  int cyc;

  typedef struct {int c; logic rst; logic [1:0] sw;} stim_t;
  typedef struct {int c; logic [1:0] m;} mc_t;
  typedef struct {int c; logic [1:0] m; logic f;} pt_t;

  stim_t stim_q[$];
  mc_t   mc_q[$];
  int    st_q[$];
  pt_t   pt_q[$];

  wind_mode_conditioner #(.DEBOUNCE_CYCLES(4), .STEP_PERIOD(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .sw_in        (sw_in),
    .mode         (mode),
    .mode_changed (mode_changed),
    .step         (step),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic add_stim(input int c, input logic r, input logic [1:0] s);
    stim_t e;
    e.c = c; e.rst = r; e.sw = s;
    stim_q.push_back(e);
  endtask

  task automatic add_mc(input int c, input logic [1:0] m);
    mc_t e;
    e.c = c; e.m = m;
    mc_q.push_back(e);
  endtask

  task automatic add_pt(input int c, input logic [1:0] m, input logic f);
    pt_t e;
    e.c = c; e.m = m; e.f = f;
    pt_q.push_back(e);
  endtask

  // steps expected every 8 edges after an anchor edge, strictly before the next anchor
  task automatic add_steps(input int a, input int b);
    for (int t = a + 8; t < b; t += 8) st_q.push_back(t);
  endtask

  // Monitor: pops expectations whenever the DUT presents a pulse, plus timed point checks
  always @(negedge clk) begin
    if (cyc >= 1 && cyc <= END_CYC) begin
      while (mc_q.size() > 0 && mc_q[0].c < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL mc_missing: no pulse at edge %0d, required mode %b", mc_q[0].c, mc_q[0].m);
        void'(mc_q.pop_front());
      end
      while (st_q.size() > 0 && st_q[0] < cyc) begin
        n_cmp++; n_bad++;
        $display("FAIL step_missing: no step at edge %0d", st_q[0]);
        void'(st_q.pop_front());
      end
      if (mode_changed) begin
        n_cmp++;
        if (mc_q.size() == 0) begin
          n_bad++;
          $display("FAIL mc_unexpected: pulse at edge %0d mode %b, required none", cyc, mode);
        end else begin
          mc_t e;
          e = mc_q.pop_front();
          if (e.c != cyc || e.m != mode) begin
            n_bad++;
            $display("FAIL mc_event: got edge %0d mode %b, required edge %0d mode %b", cyc, mode, e.c, e.m);
          end
        end
      end
      if (step) begin
        n_cmp++;
        if (st_q.size() == 0 || st_q[0] != cyc) begin
          n_bad++;
          $display("FAIL step_event: step at edge %0d, required next step at %0d", cyc,
                   (st_q.size() > 0) ? st_q[0] : -1);
        end else begin
          void'(st_q.pop_front());
        end
      end
      if (step && mode_changed) begin
        n_cmp++; n_bad++;
        $display("FAIL step_mc_overlap: both high at edge %0d, required exclusive", cyc);
      end
      while (pt_q.size() > 0 && pt_q[0].c == cyc) begin
        pt_t p;
        p = pt_q.pop_front();
        n_cmp++;
        if (mode !== p.m || fault !== p.f) begin
          n_bad++;
          $display("FAIL point@%0d: got mode %b fault %b, required mode %b fault %b",
                   cyc, mode, fault, p.m, p.f);
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    sw_in = 2'b00;

    // stimulus: value set at negedge c is first sampled at edge c+1
    add_stim(2,   1'b0, 2'b00);  // release reset
    add_stim(12,  1'b0, 2'b01);  // 3-cycle glitch
    add_stim(15,  1'b0, 2'b00);
    add_stim(27,  1'b0, 2'b01);  // clean 00->01
    add_stim(40,  1'b0, 2'b10);  // bounce 10/01
    add_stim(41,  1'b0, 2'b01);
    add_stim(42,  1'b0, 2'b10);
    add_stim(43,  1'b0, 2'b01);
    add_stim(44,  1'b0, 2'b10);
    add_stim(45,  1'b0, 2'b01);
    add_stim(46,  1'b0, 2'b10);  // hold 10
    add_stim(60,  1'b0, 2'b11);  // illegal code for 10 cycles
    add_stim(70,  1'b0, 2'b00);
    add_stim(84,  1'b0, 2'b10);
    add_stim(95,  1'b0, 2'b01);  // pending, count 3 at edge 100
    add_stim(100, 1'b1, 2'b01);  // reset mid-debounce
    add_stim(101, 1'b0, 2'b01);

    // expected mode_changed pulses and steps
    add_mc(33, 2'b01);
    add_mc(52, 2'b10);
`ifndef WIND_FAULT_EN
    add_mc(66, 2'b11);
`endif
    add_mc(76,  2'b00);
    add_mc(90,  2'b10);
    add_mc(107, 2'b01);

    add_steps(2, 33);
    add_steps(33, 52);
    add_steps(52, 66);
`ifndef WIND_FAULT_EN
    add_steps(66, 76);
`endif
    add_steps(76, 90);
    add_steps(90, 101);
    add_steps(101, 107);
    add_steps(107, END_CYC + 1);

    // point checks: mode and fault after the given edge
    add_pt(1,   2'b00, 1'b0);
    add_pt(2,   2'b00, 1'b0);
    add_pt(25,  2'b00, 1'b0);
    add_pt(32,  2'b00, 1'b0);
    add_pt(33,  2'b01, 1'b0);
    add_pt(51,  2'b01, 1'b0);
    add_pt(52,  2'b10, 1'b0);
    add_pt(65,  2'b10, 1'b0);
`ifdef WIND_FAULT_EN
    add_pt(66,  2'b10, 1'b1);
    add_pt(72,  2'b10, 1'b1);
    add_pt(73,  2'b10, 1'b0);
    add_pt(75,  2'b10, 1'b0);
`else
    add_pt(66,  2'b11, 1'b0);
    add_pt(72,  2'b11, 1'b0);
    add_pt(75,  2'b11, 1'b0);
`endif
    add_pt(76,  2'b00, 1'b0);
    add_pt(90,  2'b10, 1'b0);
    add_pt(100, 2'b10, 1'b0);
    add_pt(101, 2'b00, 1'b0);
    add_pt(106, 2'b00, 1'b0);
    add_pt(107, 2'b01, 1'b0);

    // driver: apply table entries at the negedge matching their cycle
    while (cyc <= END_CYC) begin
      @(negedge clk);
      while (stim_q.size() > 0 && stim_q[0].c == cyc) begin
        stim_t s;
        s = stim_q.pop_front();
        reset = s.rst;
        sw_in = s.sw;
      end
    end
    #1;
    foreach (mc_q[i]) begin
      n_cmp++; n_bad++;
      $display("FAIL mc_leftover: pulse required at edge %0d never seen", mc_q[i].c);
    end
    foreach (st_q[i]) begin
      n_cmp++; n_bad++;
      $display("FAIL step_leftover: step required at edge %0d never seen", st_q[i]);
    end
    foreach (pt_q[i]) begin
      n_cmp++; n_bad++;
      $display("FAIL point_leftover: check at edge %0d never reached", pt_q[i].c);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
